// File: rtl/line_buffer_pkg.sv
// -----------------------------------------------------------------------------
// line_buffer_pkg
// Shared types, widths and helpers for the line buffer in front of the
// convolution engine.
//   state_t   : block-level FSM states (IDLE waits for geometry, RUN streams)
//   CFG_WIDTH : width of the cfg_words / cfg_rows fields and the row counter
//   slot_sel  : maps an output slot to the row store that holds its row
// -----------------------------------------------------------------------------
package line_buffer_pkg;

    localparam int unsigned CFG_WIDTH = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // wr_sel always points at the store holding the oldest row, so slot 0
    // reads store wr_sel and slot k reads the k-th store after it.
    function automatic int unsigned slot_sel(
        input int unsigned wr_sel,
        input int unsigned k,
        input int unsigned n_stores
    );
        return (wr_sel + k) % n_stores;
    endfunction

endpackage

// File: rtl/line_buffer_row_store.sv
// -----------------------------------------------------------------------------
// line_buffer_row_store
// One image row of packed words. The read is asynchronous on the same address
// that is written, so a write in a cycle returns the old contents that cycle
// (read-before-write). Contents are not reset.
// Ports:
//   clk       : clock
//   we_i      : write enable
//   addr_i    : word address within the row
//   wdata_i   : word to store
//   rdata_c_o : current contents at addr_i (combinational)
// -----------------------------------------------------------------------------
module line_buffer_row_store #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_c_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata_c_o = mem_q[addr_i];

    // Storage array, written on accept only.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// Turns a raster stream of packed image words into vertically stacked
// KERNEL_HEIGHT-word columns for the convolution engine. The previous
// KERNEL_HEIGHT-1 rows live in row stores; every accepted word produces one
// registered column one cycle later once enough rows of the current frame
// have been seen.
// Ports:
//   clk        : clock
//   rst        : asynchronous active-low reset
//   cfg_words  : words per row (1..LINE_WORDS)
//   cfg_rows   : rows per frame (KERNEL_HEIGHT..65535)
//   cfg_valid  : configuration strobe
//   up_data    : input image word
//   up_valid   : input word valid
//   up_ready   : block can accept a word (high in RUN)
//   dn_image   : stacked column, slot h at [h*WORD_WIDTH +: WORD_WIDTH],
//                slot KERNEL_HEIGHT-1 is the newest row
//   dn_valid   : dn_image valid this cycle
//   frame_done : pulses with the column of the last word of a frame
// -----------------------------------------------------------------------------
module line_buffer
    import line_buffer_pkg::*;
#(
    parameter  int unsigned IMAGE_WIDTH   = 16,
    parameter  int unsigned IMAGE_NB      = 8,
    parameter  int unsigned KERNEL_HEIGHT = 3,
    parameter  int unsigned LINE_WORDS    = 64,
    localparam int unsigned WORD_WIDTH    = IMAGE_WIDTH * IMAGE_NB
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CFG_WIDTH-1:0]              cfg_words,
    input  logic [CFG_WIDTH-1:0]              cfg_rows,
    input  logic                              cfg_valid,
    input  logic [WORD_WIDTH-1:0]             up_data,
    input  logic                              up_valid,
    output logic                              up_ready,
    output logic [WORD_WIDTH*KERNEL_HEIGHT-1:0] dn_image,
    output logic                              dn_valid,
    output logic                              frame_done
);

    localparam int unsigned N_STORES = KERNEL_HEIGHT - 1;
    localparam int unsigned COL_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int unsigned WSEL_W   = (N_STORES > 1) ? $clog2(N_STORES) : 1;
    localparam int unsigned DN_W     = WORD_WIDTH * KERNEL_HEIGHT;

    state_t                state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [CFG_WIDTH-1:0]  row_q, row_d;
    logic [WSEL_W-1:0]     wr_sel_q, wr_sel_d;
    logic [CFG_WIDTH-1:0]  words_q, words_d;
    logic [CFG_WIDTH-1:0]  rows_q, rows_d;
    logic                  up_ready_q, up_ready_d;
    logic                  dn_valid_q, dn_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic [DN_W-1:0]       dn_image_q, dn_image_d;

    logic [WORD_WIDTH-1:0] rd_data_c [N_STORES];
    logic                  accept_c;
    logic                  cfg_ok_c;
    logic                  cfg_take_c;
    logic                  at_boundary_c;
    logic                  last_col_c;
    logic                  last_row_c;

    assign accept_c      = up_valid && up_ready_q;
    assign cfg_ok_c      = (cfg_words != '0)
                        && (cfg_words <= CFG_WIDTH'(LINE_WORDS))
                        && (cfg_rows >= CFG_WIDTH'(KERNEL_HEIGHT));
    assign at_boundary_c = (col_q == '0) && (row_q == '0);
    assign last_col_c    = (CFG_WIDTH'(col_q) == (words_q - CFG_WIDTH'(1)));
    assign last_row_c    = (row_q == (rows_q - CFG_WIDTH'(1)));

    // Row stores: every store is read at col, only store wr_sel is written.
    for (genvar s = 0; s < N_STORES; s++) begin : g_store
        line_buffer_row_store #(
            .DEPTH  (LINE_WORDS),
            .WIDTH  (WORD_WIDTH),
            .ADDR_W (COL_W)
        ) u_store (
            .clk       (clk),
            .we_i      (accept_c && (wr_sel_q == WSEL_W'(s))),
            .addr_i    (col_q),
            .wdata_i   (up_data),
            .rdata_c_o (rd_data_c[s])
        );
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; new geometry is only taken in IDLE or at a frame boundary.
    always_comb begin
        state_d    = state_q;
        cfg_take_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid && cfg_ok_c) begin
                    state_d    = RUN;
                    cfg_take_c = 1'b1;
                end
            end
            RUN: begin
                if (cfg_valid && at_boundary_c) begin
                    if (cfg_ok_c) begin
                        cfg_take_c = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs and column assembly.
    always_comb begin
        up_ready_d   = (state_d == RUN);
        dn_valid_d   = accept_c && (row_q >= CFG_WIDTH'(N_STORES));
        frame_done_d = accept_c && last_col_c && last_row_c;
        dn_image_d   = dn_image_q;
        if (dn_valid_d) begin
            for (int unsigned k = 0; k < N_STORES; k++) begin
                dn_image_d[k*WORD_WIDTH +: WORD_WIDTH] =
                    rd_data_c[WSEL_W'(slot_sel(32'(wr_sel_q), k, N_STORES))];
            end
            dn_image_d[N_STORES*WORD_WIDTH +: WORD_WIDTH] = up_data;
        end
    end

    // Raster counters and latched geometry.
    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        wr_sel_d = wr_sel_q;
        words_d  = words_q;
        rows_d   = rows_q;
        if (accept_c) begin
            if (last_col_c) begin
                col_d    = '0;
                wr_sel_d = (wr_sel_q == WSEL_W'(N_STORES - 1)) ? '0 : wr_sel_q + WSEL_W'(1);
                row_d    = last_row_c ? '0 : row_q + CFG_WIDTH'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
        if (cfg_take_c) begin
            words_d = cfg_words;
            rows_d  = cfg_rows;
        end
        // Leaving RUN always starts the next configuration from a clean raster.
        if ((state_q == RUN) && (state_d == IDLE)) begin
            col_d = '0;
            row_d = '0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            wr_sel_q     <= '0;
            words_q      <= '0;
            rows_q       <= '0;
            up_ready_q   <= 1'b0;
            dn_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            dn_image_q   <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            wr_sel_q     <= wr_sel_d;
            words_q      <= words_d;
            rows_q       <= rows_d;
            up_ready_q   <= up_ready_d;
            dn_valid_q   <= dn_valid_d;
            frame_done_q <= frame_done_d;
            dn_image_q   <= dn_image_d;
        end
    end

    assign up_ready   = up_ready_q;
    assign dn_valid   = dn_valid_q;
    assign frame_done = frame_done_q;
    assign dn_image   = dn_image_q;

endmodule

// File: tb/tb_line_buffer.sv
// -----------------------------------------------------------------------------
// tb_line_buffer
// Directed bench for line_buffer with KERNEL_HEIGHT=3, one 16-bit pixel per
// word and pixel value row*16+col (plus an optional per-frame offset).
// -----------------------------------------------------------------------------
module tb_line_buffer;

    localparam int unsigned IW = 16;
    localparam int unsigned NB = 1;
    localparam int unsigned KH = 3;
    localparam int unsigned LW = 64;
    localparam int unsigned WW = IW * NB;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [15:0]        cfg_words = '0;
    logic [15:0]        cfg_rows  = '0;
    logic               cfg_valid = 1'b0;
    logic [WW-1:0]      up_data   = '0;
    logic               up_valid  = 1'b0;
    logic               up_ready;
    logic [WW*KH-1:0]   dn_image;
    logic               dn_valid;
    logic               frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    // Columns of a 4x4 frame, slot 2 (newest row) in the top 16 bits.
    logic [47:0] exp_tab [8] = '{
        48'h0020_0010_0000, 48'h0021_0011_0001, 48'h0022_0012_0002, 48'h0023_0013_0003,
        48'h0030_0020_0010, 48'h0031_0021_0011, 48'h0032_0022_0012, 48'h0033_0023_0013
    };

    line_buffer #(
        .IMAGE_WIDTH   (IW),
        .IMAGE_NB      (NB),
        .KERNEL_HEIGHT (KH),
        .LINE_WORDS    (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_words  (cfg_words),
        .cfg_rows   (cfg_rows),
        .cfg_valid  (cfg_valid),
        .up_data    (up_data),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .dn_image   (dn_image),
        .dn_valid   (dn_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int gap_len(input int idx);
        if (idx % 3 == 1) return 2;
        if (idx % 5 == 0) return 1;
        return 0;
    endfunction

    task automatic send_cfg(input logic [15:0] w, input logic [15:0] r);
        cfg_words = w;
        cfg_rows  = r;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    // Stream a 4x4 frame (or its first n_send words) and check every column.
    task automatic stream(input logic [15:0] ofs, input bit gaps, input int cfg_at,
                          input int n_send, input bit tail);
        int vcnt;
        int fcnt;
        int idx;
        bit exp_v;
        vcnt = 0;
        fcnt = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                idx = r * 4 + c;
                if (idx < n_send) begin
                    if (gaps) begin
                        for (int g = 0; g < gap_len(idx); g++) begin
                            up_valid = 1'b0;
                            step();
                            check("gap_quiet", 48'(dn_valid), 48'd0);
                            vcnt += int'(dn_valid);
                        end
                    end
                    check("ready", 48'(up_ready), 48'd1);
                    up_valid = 1'b1;
                    up_data  = ofs + 16'(r * 16 + c);
                    if (idx == cfg_at) begin
                        cfg_words = 16'd2;
                        cfg_rows  = 16'd3;
                        cfg_valid = 1'b1;
                    end
                    step();
                    up_valid  = 1'b0;
                    cfg_valid = 1'b0;
                    exp_v = (r >= 2);
                    check("dn_valid", 48'(dn_valid), 48'(exp_v));
                    check("frame_done", 48'(frame_done), 48'((r == 3) && (c == 3)));
                    if (exp_v) begin
                        check("dn_image", dn_image, exp_tab[(r - 2) * 4 + c] + {3{ofs}});
                    end
                    vcnt += int'(dn_valid);
                    fcnt += int'(frame_done);
                end
            end
        end
        if (n_send >= 16) begin
            check("n_valid", 48'(vcnt), 48'd8);
            check("n_frame_done", 48'(fcnt), 48'd1);
        end
        if (tail) begin
            step();
            check("idle_no_valid", 48'(dn_valid), 48'd0);
            check("image_hold", dn_image, exp_tab[7] + {3{ofs}});
        end
    endtask

    initial begin
        int leak;
        // Reset with up_valid already asserted.
        up_valid = 1'b1;
        up_data  = 16'hABCD;
        #3 rst = 1'b0;
        #1;
        check("rst_ready", 48'(up_ready), 48'd0);
        check("rst_valid", 48'(dn_valid), 48'd0);
        check("rst_done", 48'(frame_done), 48'd0);
        check("rst_image", dn_image, 48'd0);
        step();
        step();
        rst = 1'b1;
        leak = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            leak += int'(up_ready) + int'(dn_valid);
        end
        check("no_cfg_gated", 48'(leak), 48'd0);
        up_valid = 1'b0;

        // Out-of-range configurations are ignored.
        send_cfg(16'd0, 16'd4);
        step();
        check("cfg_words0", 48'(up_ready), 48'd0);
        send_cfg(16'd4, 16'd2);
        step();
        check("cfg_rows2", 48'(up_ready), 48'd0);
        send_cfg(16'd65, 16'd4);
        step();
        check("cfg_words65", 48'(up_ready), 48'd0);

        // Valid configuration enters RUN.
        send_cfg(16'd4, 16'd4);
        check("cfg_ok_ready", 48'(up_ready), 48'd1);

        // Nominal continuous frame.
        stream(16'h0000, 1'b0, -1, 16, 1'b1);

        // Same frame with bubbles in up_valid.
        stream(16'h0000, 1'b1, -1, 16, 1'b1);

        // Back-to-back frames; the second must re-prime from its own rows.
        stream(16'h0500, 1'b0, -1, 16, 1'b0);
        stream(16'h0000, 1'b0, -1, 16, 1'b1);

        // cfg_valid mid-frame (row1,col2) is ignored: geometry stays 4x4.
        stream(16'h0000, 1'b0, 6, 16, 1'b1);

        // Reset mid-frame at row2,col1.
        stream(16'h0000, 1'b0, -1, 9, 1'b0);
        check("pre_rst_valid", 48'(dn_valid), 48'd1);
        up_valid = 1'b1;
        up_data  = 16'h0021;
        #2 rst = 1'b0;
        #1;
        check("async_valid_drop", 48'(dn_valid), 48'd0);
        check("async_ready_drop", 48'(up_ready), 48'd0);
        check("async_image_clr", dn_image, 48'd0);
        step();
        rst = 1'b1;
        leak = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            leak += int'(up_ready) + int'(dn_valid);
        end
        check("post_rst_idle", 48'(leak), 48'd0);
        up_valid = 1'b0;

        // New configuration after reset, fresh frame.
        send_cfg(16'd4, 16'd4);
        check("recfg_ready", 48'(up_ready), 48'd1);
        stream(16'h0000, 1'b0, -1, 16, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
